// File: rtl/adc_link_pkg.sv
// Shared types and constants for the ADC LVDS link bring-up sequencer.
package adc_link_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLockWait,
    StRxRst,
    StSettle,
    StCheck,
    StSlip,
    StAligned,
    StFail
  } state_e;

  // Word the ADC drives on the frame lane once the deserializer is word-aligned.
  localparam logic [7:0] FRAME_PATTERN = 8'hF0;

  localparam int unsigned DEF_LOCK_CYCLES    = 16;
  localparam int unsigned DEF_RX_RST_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES  = 4;
  localparam int unsigned DEF_MAX_SLIPS      = 8;
  localparam int unsigned DEF_RETRY_LIMIT    = 3;
  localparam int unsigned DEF_MISMATCH_LIMIT = 4;

  // Width of the shared phase timer.
  localparam int unsigned TIMER_W = 16;

  function automatic logic is_busy(input state_e s);
    return !(s inside {StIdle, StAligned, StFail});
  endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module link_timer
  import adc_link_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_dec,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/adc_link_sequencer.sv
// Bring-up and supervision FSM for one fast-ADC LVDS link: PLL lock qualification,
// deserializer reset, bitslip word alignment with retries, and in-service monitoring.
module adc_link_sequencer
  import adc_link_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned RX_RST_CYCLES  = DEF_RX_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_SLIPS      = DEF_MAX_SLIPS,
  parameter int unsigned RETRY_LIMIT    = DEF_RETRY_LIMIT,
  parameter int unsigned MISMATCH_LIMIT = DEF_MISMATCH_LIMIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_pll_locked,
  input  logic [7:0] i_frm_data,
  output logic       o_rx_reset,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_error,
  output logic       o_busy,
  output logic [3:0] o_slip_count,
  output logic [7:0] o_relock_count
);

  // Timer reload values are "cycles - 1": the phase ends on the cycle the count hits zero.
  localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RX_RST_LOAD = TIMER_W'(RX_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]         MAX_SLIP_C  = 4'(MAX_SLIPS);
  localparam logic [7:0]         RETRY_C     = 8'(RETRY_LIMIT);
  localparam logic [7:0]         MISMATCH_C  = 8'(MISMATCH_LIMIT);

  state_e             r_state;
  state_e             w_next;
  logic               r_rx_reset;
  logic               r_bitslip;
  logic               r_aligned;
  logic               r_error;
  logic               r_busy;
  logic [3:0]         r_slip_count;
  logic [7:0]         r_relock_count;
  logic [7:0]         r_retry_count;
  logic [7:0]         r_mismatch_count;
  logic               w_frame_ok;
  logic               w_mismatch_hit;
  logic               w_tmr_load;
  logic               w_tmr_dec;
  logic               w_tmr_done;
  logic [TIMER_W-1:0] w_tmr_val;

  assign w_frame_ok     = (i_frm_data == FRAME_PATTERN);
  assign w_mismatch_hit = !w_frame_ok && ((r_mismatch_count + 8'd1) == MISMATCH_C);

  link_timer u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_dec      (w_tmr_dec),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Next-state decode; PLL loss in any busy state or in ALIGNED restarts lock qualification.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle:     if (i_start) w_next = StLockWait;
      StLockWait: if (i_pll_locked && w_tmr_done) w_next = StRxRst;
      StRxRst: begin
        if (!i_pll_locked)   w_next = StLockWait;
        else if (w_tmr_done) w_next = StSettle;
      end
      StSettle: begin
        if (!i_pll_locked)   w_next = StLockWait;
        else if (w_tmr_done) w_next = StCheck;
      end
      StCheck: begin
        if (!i_pll_locked)                            w_next = StLockWait;
        else if (w_frame_ok)                          w_next = StAligned;
        else if (r_slip_count < MAX_SLIP_C)           w_next = StSlip;
        else if ((r_retry_count + 8'd1) == RETRY_C)   w_next = StFail;
        else                                          w_next = StRxRst;
      end
      StSlip:    w_next = i_pll_locked ? StSettle : StLockWait;
      StAligned: if (!i_pll_locked || w_mismatch_hit) w_next = StLockWait;
      StFail:    if (i_start) w_next = StLockWait;
      default:   w_next = StIdle;
    endcase
  end

  // Timer is reloaded on every state entry, and on each low lock sample while qualifying.
  always_comb begin
    w_tmr_load = (w_next != r_state) || ((r_state == StLockWait) && !i_pll_locked);
    w_tmr_dec  = !w_tmr_load;
    case (w_next)
      StLockWait: w_tmr_val = LOCK_LOAD;
      StRxRst:    w_tmr_val = RX_RST_LOAD;
      StSettle:   w_tmr_val = SETTLE_LOAD;
      default:    w_tmr_val = '0;
    endcase
  end

  // State, bookkeeping counters and Moore outputs registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= StIdle;
      r_rx_reset       <= 1'b0;
      r_bitslip        <= 1'b0;
      r_aligned        <= 1'b0;
      r_error          <= 1'b0;
      r_busy           <= 1'b0;
      r_slip_count     <= '0;
      r_relock_count   <= '0;
      r_retry_count    <= '0;
      r_mismatch_count <= '0;
    end else begin
      r_state    <= w_next;
      r_rx_reset <= (w_next == StRxRst);
      r_bitslip  <= (w_next == StSlip);
      r_aligned  <= (w_next == StAligned);
      r_error    <= (w_next == StFail);
      r_busy     <= is_busy(w_next);

      if (w_next == StRxRst)     r_slip_count <= '0;
      else if (w_next == StSlip) r_slip_count <= r_slip_count + 4'd1;

      if (((r_state == StIdle) || (r_state == StFail)) && (w_next == StLockWait)) begin
        r_retry_count <= '0;
      end else if ((r_state == StAligned) && (w_next != StAligned)) begin
        r_retry_count <= '0;
      end else if ((r_state == StCheck) && ((w_next == StRxRst) || (w_next == StFail))) begin
        r_retry_count <= r_retry_count + 8'd1;
      end

      if ((r_state == StAligned) && (w_next == StAligned)) begin
        r_mismatch_count <= w_frame_ok ? 8'd0 : (r_mismatch_count + 8'd1);
      end else begin
        r_mismatch_count <= '0;
      end

      if ((r_state == StAligned) && (w_next != StAligned) && (r_relock_count != 8'hFF)) begin
        r_relock_count <= r_relock_count + 8'd1;
      end
    end
  end

  assign o_rx_reset     = r_rx_reset;
  assign o_bitslip      = r_bitslip;
  assign o_aligned      = r_aligned;
  assign o_error        = r_error;
  assign o_busy         = r_busy;
  assign o_slip_count   = r_slip_count;
  assign o_relock_count = r_relock_count;

endmodule

// File: doc/adc_link_sequencer.md
# adc_link_sequencer

Bring-up and supervision controller for one fast-ADC LVDS link. After `start`, it waits for a stable LVDS PLL lock and pulses the deserializer reset. It then walks `bitslip` until the frame lane shows the expected frame pattern, retrying the whole sequence a bounded number of times. Once aligned, it watches for loss of lock or frame corruption and re-runs alignment automatically. It sits between the LVDS receiver and the ADC acquisition datapath, and gates that datapath with `aligned`.

## Interface
Parameters:
- `LOCK_CYCLES`, 16: consecutive cycles `pll_locked` must be high before proceeding (≥1).
- `RX_RST_CYCLES`, 4: width of the `rx_reset` pulse, in cycles (≥1).
- `SETTLE_CYCLES`, 4: wait after a reset or slip before the frame is checked (≥1).
- `MAX_SLIPS`, 8: slips tried per attempt; equals the deserialization factor.
- `RETRY_LIMIT`, 3: full attempts before failure (≥1).
- `MISMATCH_LIMIT`, 4: consecutive bad frames that count as loss of alignment (≥1).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin or restart the sequence; sampled in IDLE and FAIL only.
- `pll_locked` in 1: LVDS PLL lock, already synchronized to `clk`.
- `frm_data` in 8: deserialized frame-lane word.
- `rx_reset` out 1: deserializer reset.
- `bitslip` out 1: one-cycle slip request.
- `aligned` out 1: link aligned; datapath may consume samples.
- `error` out 1: retries exhausted.
- `busy` out 1: high in every state except IDLE, ALIGNED and FAIL.
- `slip_count` out 4: slips issued in the current attempt.
- `relock_count` out 8: number of alignment losses; saturates at 255.

## Operation
- Decided: reset `reset`, synchronous, active-high; clock `clk`.
- Reset value of every output is 0; state goes to IDLE. A reset asserted mid-sequence aborts the sequence immediately.
- All outputs are registered and decoded from the registered state (Moore).
- IDLE: on `start` → LOCK_WAIT; the lock counter and retry counter are cleared.
- LOCK_WAIT: the counter increments while `pll_locked` = 1 and clears on 0. After `LOCK_CYCLES` consecutive high samples → RX_RST.
- RX_RST: `rx_reset` = 1 for exactly `RX_RST_CYCLES` cycles; `slip_count` is cleared. Then → SETTLE.
- SETTLE: lasts `SETTLE_CYCLES` cycles, then → CHECK.
- CHECK (1 cycle):
  - `frm_data` == 8'hF0 → ALIGNED.
  - Otherwise, if `slip_count` < `MAX_SLIPS` → SLIP.
  - Otherwise the retry counter increments. If it reaches `RETRY_LIMIT` → FAIL; else → RX_RST.
- SLIP (1 cycle): `bitslip` = 1 and `slip_count` increments. Then → SETTLE.
- ALIGNED:
  - `aligned` = 1.
  - A mismatch counter increments on each `frm_data` ≠ 8'hF0 and clears on a match.
  - When the mismatch counter reaches `MISMATCH_LIMIT` → LOCK_WAIT.
  - When `pll_locked` = 0 → LOCK_WAIT on the next edge; if both conditions hit in the same cycle, the PLL loss is taken.
  - On leaving ALIGNED, `relock_count` increments (saturating) and the retry counter clears.
- FAIL: `error` = 1. `start` → LOCK_WAIT with `error` cleared and counters reset.
- In every state outside ALIGNED, `pll_locked` = 0 returns to LOCK_WAIT. `rx_reset` and `bitslip` deassert on that same edge.
- `start` is ignored while `busy` or `aligned` is high.

## Timing
- With `start` sampled in cycle 0 and the PLL locked throughout:
  - LOCK_WAIT: cycles 1..`LOCK_CYCLES`.
  - RX_RST: next `RX_RST_CYCLES` cycles.
  - SETTLE: next `SETTLE_CYCLES` cycles.
  - CHECK: 1 cycle.
- `aligned` rises at cycle `LOCK_CYCLES`+`RX_RST_CYCLES`+`SETTLE_CYCLES`+2 (26 with default parameters).
- Each slip adds `SETTLE_CYCLES`+2 cycles.
- `bitslip` pulses are never adjacent; they are separated by at least `SETTLE_CYCLES`+1 low cycles.
- `aligned` falls on the edge after the `MISMATCH_LIMIT`-th consecutive bad word, or the edge after `pll_locked` is sampled low.

## Structure
- Package `adc_link_pkg` holds:
  - The state enum: IDLE, LOCK_WAIT, RX_RST, SETTLE, CHECK, SLIP, ALIGNED, FAIL.
  - `FRAME_PATTERN` = 8'hF0.
  - The default parameter constants.
- Sub-module `link_timer`: a loadable down-counter with a `done` flag, shared by LOCK_WAIT (reloaded on any low lock sample), RX_RST and SETTLE.

## Test plan
- PLL locked from cycle 0, `frm_data` = F0, pulse `start` → `rx_reset` high cycles 17–20, `aligned` = 1 at cycle 26, no `bitslip`.
- `frm_data` = 8'hF0 rotated by 3 bits; each `bitslip` rotates the model by one bit → exactly 3 `bitslip` pulses each 6 cycles apart, `slip_count` = 3, `aligned` = 1.
- `frm_data` stuck at 8'h00 → 3 attempts × 8 slips, 3 `rx_reset` pulses, then `error` = 1, `busy` = 0; a later `start` clears `error`.
- `pll_locked` drops at cycle 10 of LOCK_WAIT → counter restarts, and `rx_reset` appears `LOCK_CYCLES` cycles after lock returns.
- In ALIGNED, inject 3 bad words then 1 good word → stays aligned. Inject 4 bad words → `aligned` = 0, `relock_count` = 1, and realignment completes.
- Assert `reset` during SLIP → all outputs 0 on the next cycle, state IDLE; `start` afterwards repeats the sequence from the beginning.
